// File: rtl/snake_food_manager.sv
// -----------------------------------------------------------------------------
// snake_food_manager
//
// Food subsystem for the Snake game. Keeps up to NUM_FOOD food items on the
// playfield cell grid. Each eaten item is respawned at an LFSR-random free cell
// (not on another food item and not on the snake body, which is asked through
// a query handshake). It also produces the food icon for the pixel being
// scanned.
//
// Ports:
//   Clock           system clock, all state on rising edge
//   Reset           asynchronous, active-low
//   iPixelRow/Col   scan position (11 bits each)
//   iEaten          one-cycle pulse per slot eaten
//   iGameOver       freezes spawning and hides icons
//   oQueryValid     body-occupancy query request
//   oQueryX/Y       candidate cell, zero-extended to 8 bits
//   iQueryReady     body block accepts the query this cycle
//   iQueryHit       candidate occupied (valid when oQueryValid && iQueryReady)
//   oFoodValid      per-slot live flag
//   oFoodLocationX/Y  top-left pixel of slot i at bits [11i+10:11i]
//   oFoodIcon       2'b11 on a food pixel (one cycle after the scan position)
//   oSpawnFail      sticky: a spawn ran out of attempts
//   oBusy           spawn FSM not idle
// -----------------------------------------------------------------------------
module snake_food_manager #(
    parameter int          NUM_FOOD  = 2,
    parameter int          GRID_W    = 64,
    parameter int          GRID_H    = 64,
    parameter int          CELL_BITS = 2,
    parameter int          ORIGIN_X  = 192,
    parameter int          ORIGIN_Y  = 112,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [10:0]             iPixelRow,
    input  logic [10:0]             iPixelCol,
    input  logic [NUM_FOOD-1:0]     iEaten,
    input  logic                    iGameOver,
    output logic                    oQueryValid,
    output logic [7:0]              oQueryX,
    output logic [7:0]              oQueryY,
    input  logic                    iQueryReady,
    input  logic                    iQueryHit,
    output logic [NUM_FOOD-1:0]     oFoodValid,
    output logic [11*NUM_FOOD-1:0]  oFoodLocationX,
    output logic [11*NUM_FOOD-1:0]  oFoodLocationY,
    output logic [1:0]              oFoodIcon,
    output logic                    oSpawnFail,
    output logic                    oBusy
);

    localparam int         TW    = $clog2(MAX_TRIES + 1);
    localparam logic [7:0] XMASK = 8'((1 << $clog2(GRID_W)) - 1);
    localparam logic [7:0] YMASK = 8'((1 << $clog2(GRID_H)) - 1);
    localparam logic [8:0] GW    = 9'(GRID_W);
    localparam logic [8:0] GH    = 9'(GRID_H);
    localparam logic [10:0] OX   = 11'(ORIGIN_X);
    localparam logic [10:0] OY   = 11'(ORIGIN_Y);
    localparam logic [11:0] CELL = 12'(1 << CELL_BITS);

    typedef enum logic [1:0] {IDLE, DRAW, QUERY, COMMIT} state_t;

    state_t                 state, state_nxt;
    logic [15:0]            lfsr;
    logic [NUM_FOOD-1:0]    pending, pending_nxt;
    logic [NUM_FOOD-1:0]    food_valid, valid_nxt;
    logic [10:0]            loc_x [NUM_FOOD];
    logic [10:0]            loc_y [NUM_FOOD];
    logic [1:0]             sel_idx, first_pending;
    logic [NUM_FOOD-1:0]    sel_oh;
    logic [TW-1:0]          tries;
    logic                   tries_last;
    logic                   spawn_fail;
    logic [7:0]             draw_x, draw_y;
    logic [10:0]            draw_px, draw_py;
    logic                   draw_reject;
    logic [7:0]             cand_x, cand_y;
    logic                   retry, give_up, commit;
    logic                   icon_hit;
    logic                   icon_p1;

    // Cell index -> top-left pixel coordinate.
    function automatic logic [10:0] cell_to_px(input logic [7:0] c, input logic [10:0] org);
        return org + (11'(c) << CELL_BITS);
    endfunction

    // True when pixel p lies inside the cell starting at pixel base.
    function automatic logic in_cell(input logic [10:0] p, input logic [10:0] base);
        return ({1'b0, p} >= {1'b0, base}) && ({1'b0, p} < ({1'b0, base} + CELL));
    endfunction

    assign sel_oh     = NUM_FOOD'(1) << sel_idx;
    assign tries_last = (tries == TW'(MAX_TRIES - 1));

    // Lowest-index pending slot, latched when leaving IDLE.
    always_comb begin
        first_pending = '0;
        for (int j = NUM_FOOD - 1; j >= 0; j--) begin
            if (pending[j]) first_pending = 2'(j);
        end
    end

    // Candidate from the current LFSR state; rejected if off-grid or on
    // another live food item.
    always_comb begin
        draw_x      = lfsr[7:0] & XMASK;
        draw_y      = lfsr[15:8] & YMASK;
        draw_px     = cell_to_px(draw_x, OX);
        draw_py     = cell_to_px(draw_y, OY);
        draw_reject = ({1'b0, draw_x} >= GW) || ({1'b0, draw_y} >= GH);
        for (int j = 0; j < NUM_FOOD; j++) begin
            if (!sel_oh[j] && food_valid[j] && loc_x[j] == draw_px && loc_y[j] == draw_py)
                draw_reject = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        retry     = 1'b0;
        case (state)
            IDLE:   if (pending != '0 && !iGameOver) state_nxt = DRAW;
            DRAW:   if (draw_reject) retry = 1'b1;
                    else             state_nxt = QUERY;
            QUERY:  if (iQueryReady) begin
                        if (iQueryHit) retry = 1'b1;
                        else           state_nxt = COMMIT;
                    end
            COMMIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (retry) state_nxt = tries_last ? IDLE : DRAW;
        // Game over aborts whatever is in flight; pending bits survive.
        if (iGameOver) begin
            state_nxt = IDLE;
            retry     = 1'b0;
        end
    end

    assign give_up = retry && tries_last;
    assign commit  = (state == COMMIT) && !iGameOver;

    // Eaten pulses only count on live slots; the slot being spawned is
    // invalid, so a pulse on it is naturally ignored.
    always_comb begin
        pending_nxt = pending | (iEaten & food_valid);
        valid_nxt   = food_valid & ~iEaten;
        if (commit || give_up) pending_nxt = pending_nxt & ~sel_oh;
        if (commit)            valid_nxt   = valid_nxt | sel_oh;
    end

    always_comb begin
        icon_hit = 1'b0;
        if (!iGameOver) begin
            for (int j = 0; j < NUM_FOOD; j++) begin
                if (food_valid[j] && in_cell(iPixelCol, loc_x[j]) && in_cell(iPixelRow, loc_y[j]))
                    icon_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            pending    <= '1;
            food_valid <= '0;
            spawn_fail <= 1'b0;
            tries      <= '0;
            sel_idx    <= '0;
            icon_p1    <= 1'b0;
            for (int j = 0; j < NUM_FOOD; j++) begin
                loc_x[j] <= '0;
                loc_y[j] <= '0;
            end
        end else begin
            state      <= state_nxt;
            lfsr       <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            pending    <= pending_nxt;
            food_valid <= valid_nxt;
            if (give_up) spawn_fail <= 1'b1;
            if (state == IDLE) begin
                tries   <= '0;
                sel_idx <= first_pending;
            end else if (retry) begin
                tries <= tries + 1'b1;
            end
            for (int j = 0; j < NUM_FOOD; j++) begin
                if (commit && sel_oh[j]) begin
                    loc_x[j] <= cell_to_px(cand_x, OX);
                    loc_y[j] <= cell_to_px(cand_y, OY);
                end
            end
            // icon stage: scan pixel of previous cycle -> p1
            icon_p1 <= icon_hit;
        end
    end

    // Candidate cell is pure data; it is only meaningful in QUERY/COMMIT,
    // which are always entered from DRAW where it is loaded.
    always_ff @(posedge Clock) begin
        if (state == DRAW) begin
            cand_x <= draw_x;
            cand_y <= draw_y;
        end
    end

    for (genvar g = 0; g < NUM_FOOD; g++) begin : g_loc
        assign oFoodLocationX[11*g +: 11] = loc_x[g];
        assign oFoodLocationY[11*g +: 11] = loc_y[g];
    end

    assign oQueryValid = (state == QUERY);
    assign oQueryX     = cand_x;
    assign oQueryY     = cand_y;
    assign oFoodValid  = food_valid;
    assign oFoodIcon   = {2{icon_p1}};
    assign oSpawnFail  = spawn_fail;
    assign oBusy       = (state != IDLE);

endmodule

// File: tb/tb_snake_food_manager.sv
// -----------------------------------------------------------------------------
// tb_snake_food_manager
//
// Directed bench for snake_food_manager with default parameters. Expected
// food locations come from an independent model of the 16-bit LFSR, sampled
// at the cycle the spawn FSM is known to be in its draw step.
// -----------------------------------------------------------------------------
module tb_snake_food_manager;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [10:0] iPixelRow, iPixelCol;
    logic [1:0]  iEaten;
    logic        iGameOver;
    logic        oQueryValid;
    logic [7:0]  oQueryX, oQueryY;
    logic        iQueryReady, iQueryHit;
    logic [1:0]  oFoodValid;
    logic [21:0] oFoodLocationX, oFoodLocationY;
    logic [1:0]  oFoodIcon;
    logic        oSpawnFail, oBusy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_lfsr;
    logic [15:0] l_snap;
    int          e0x, e0y, e1x, e1y, ex, ey;
    int          ecx, ecy;
    int          accepts;
    logic        done;

    snake_food_manager dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iPixelRow      (iPixelRow),
        .iPixelCol      (iPixelCol),
        .iEaten         (iEaten),
        .iGameOver      (iGameOver),
        .oQueryValid    (oQueryValid),
        .oQueryX        (oQueryX),
        .oQueryY        (oQueryY),
        .iQueryReady    (iQueryReady),
        .iQueryHit      (iQueryHit),
        .oFoodValid     (oFoodValid),
        .oFoodLocationX (oFoodLocationX),
        .oFoodLocationY (oFoodLocationY),
        .oFoodIcon      (oFoodIcon),
        .oSpawnFail     (oSpawnFail),
        .oBusy          (oBusy)
    );

    always #5 Clock = ~Clock;

    // Reference LFSR: Fibonacci, taps 15/13/12/10, seed ACE1.
    always @(posedge Clock or negedge Reset) begin
        if (!Reset) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic int cell_x(input logic [15:0] l);
        return int'(l[7:0] & 8'd63);
    endfunction
    function automatic int cell_y(input logic [15:0] l);
        return int'(l[15:8] & 8'd63);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        Reset       = 1'b0;
        iPixelRow   = '0;
        iPixelCol   = '0;
        iEaten      = '0;
        iGameOver   = 1'b0;
        iQueryReady = 1'b1;
        iQueryHit   = 1'b0;
        tick(3);

        // reset values
        check("rst_valid",  32'(oFoodValid), 0);
        check("rst_locx",   32'(oFoodLocationX), 0);
        check("rst_locy",   32'(oFoodLocationY), 0);
        check("rst_icon",   32'(oFoodIcon), 0);
        check("rst_qvalid", 32'(oQueryValid), 0);
        check("rst_fail",   32'(oSpawnFail), 0);
        check("rst_busy",   32'(oBusy), 0);

        // initial spawn of both slots
        Reset = 1'b1;
        tick(1);
        check("init_busy_draw", 32'(oBusy), 1);
        l_snap = m_lfsr;
        e0x = 192 + 4 * cell_x(l_snap);
        e0y = 112 + 4 * cell_y(l_snap);
        tick(2);
        check("init_valid_e3", 32'(oFoodValid), 0);
        tick(1);
        check("init_valid_e4", 32'(oFoodValid), 1);
        check("init_loc0x", 32'(oFoodLocationX[10:0]), 32'(e0x));
        check("init_loc0y", 32'(oFoodLocationY[10:0]), 32'(e0y));
        tick(1);
        l_snap = m_lfsr;
        e1x = 192 + 4 * cell_x(l_snap);
        e1y = 112 + 4 * cell_y(l_snap);
        ecx = cell_x(l_snap);
        ecy = cell_y(l_snap);
        tick(1);
        check("init_q1_valid", 32'(oQueryValid), 1);
        check("init_q1_x", 32'(oQueryX), 32'(ecx));
        check("init_q1_y", 32'(oQueryY), 32'(ecy));
        tick(2);
        check("init_valid_e8", 32'(oFoodValid), 3);
        check("init_loc1x", 32'(oFoodLocationX[21:11]), 32'(e1x));
        check("init_loc1y", 32'(oFoodLocationY[21:11]), 32'(e1y));
        check("init_idle", 32'(oBusy), 0);

        // eat slot 0, best-case respawn
        iEaten = 2'b01;
        tick(1);
        iEaten = 2'b00;
        check("eat_valid_cleared", 32'(oFoodValid), 2);
        tick(1);
        l_snap = m_lfsr;
        ex = 192 + 4 * cell_x(l_snap);
        ey = 112 + 4 * cell_y(l_snap);
        tick(3);
        check("eat_valid_back", 32'(oFoodValid), 3);
        check("eat_loc0x", 32'(oFoodLocationX[10:0]), 32'(ex));
        check("eat_loc0y", 32'(oFoodLocationY[10:0]), 32'(ey));
        check("eat_loc1x_kept", 32'(oFoodLocationX[21:11]), 32'(e1x));
        check("eat_loc1y_kept", 32'(oFoodLocationY[21:11]), 32'(e1y));

        // query stalled by iQueryReady low for 10 cycles
        iQueryReady = 1'b0;
        iEaten = 2'b01;
        tick(1);
        iEaten = 2'b00;
        tick(1);
        l_snap = m_lfsr;
        ecx = cell_x(l_snap);
        ecy = cell_y(l_snap);
        tick(1);
        for (int k = 0; k < 10; k++) begin
            check("stall_qvalid", 32'(oQueryValid), 1);
            check("stall_qx", 32'(oQueryX), 32'(ecx));
            check("stall_qy", 32'(oQueryY), 32'(ecy));
            tick(1);
        end
        iQueryReady = 1'b1;
        tick(1);
        check("stall_commit_valid", 32'(oFoodValid), 2);
        check("stall_commit_qvalid", 32'(oQueryValid), 0);
        tick(1);
        check("stall_done_valid", 32'(oFoodValid), 3);
        check("stall_loc0x", 32'(oFoodLocationX[10:0]), 32'(192 + 4 * ecx));
        check("stall_loc0y", 32'(oFoodLocationY[10:0]), 32'(112 + 4 * ecy));

        // game over during QUERY aborts, spawn resumes afterwards
        iQueryReady = 1'b0;
        iEaten = 2'b01;
        tick(1);
        iEaten = 2'b00;
        tick(2);
        check("go_in_query", 32'(oQueryValid), 1);
        iGameOver = 1'b1;
        tick(1);
        check("go_qvalid_low", 32'(oQueryValid), 0);
        check("go_idle", 32'(oBusy), 0);
        check("go_icon", 32'(oFoodIcon), 0);
        tick(2);
        check("go_frozen", 32'(oBusy), 0);
        check("go_slot_invalid", 32'(oFoodValid), 2);
        iGameOver   = 1'b0;
        iQueryReady = 1'b1;
        tick(1);
        check("go_resume_busy", 32'(oBusy), 1);
        l_snap = m_lfsr;
        ex = 192 + 4 * cell_x(l_snap);
        ey = 112 + 4 * cell_y(l_snap);
        tick(3);
        check("go_resume_valid", 32'(oFoodValid), 3);
        check("go_resume_locx", 32'(oFoodLocationX[10:0]), 32'(ex));
        check("go_resume_locy", 32'(oFoodLocationY[10:0]), 32'(ey));

        // icon around slot 1's cell
        iPixelCol = 11'(e1x + 1);
        iPixelRow = 11'(e1y + 1);
        tick(1);
        check("icon_inside", 32'(oFoodIcon), 3);
        iPixelCol = 11'(e1x + 4);
        tick(1);
        check("icon_right_edge", 32'(oFoodIcon), 0);
        iPixelCol = 11'(e1x + 3);
        iPixelRow = 11'(e1y + 3);
        tick(1);
        check("icon_corner", 32'(oFoodIcon), 3);
        iPixelCol = 11'(e1x - 1);
        tick(1);
        check("icon_left_edge", 32'(oFoodIcon), 0);
        iPixelCol = 11'(e1x);
        iPixelRow = 11'(e1y + 4);
        tick(1);
        check("icon_bottom_edge", 32'(oFoodIcon), 0);
        iPixelRow = 11'(e1y);
        tick(1);
        check("icon_top_left", 32'(oFoodIcon), 3);
        iGameOver = 1'b1;
        tick(1);
        check("icon_gameover", 32'(oFoodIcon), 0);
        iGameOver = 1'b0;
        iPixelRow = '0;
        iPixelCol = '0;
        tick(1);

        // every query hits: MAX_TRIES accepted queries then give up
        check("fail_before", 32'(oSpawnFail), 0);
        iQueryHit = 1'b1;
        iEaten    = 2'b01;
        tick(1);
        iEaten  = 2'b00;
        accepts = 0;
        done    = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tick(1);
            if (oQueryValid && iQueryReady) accepts++;
            if (!oBusy) begin
                done = 1'b1;
                break;
            end
        end
        check("fail_terminated", 32'(done), 1);
        check("fail_accepts", 32'(accepts), 8);
        check("fail_sticky", 32'(oSpawnFail), 1);
        check("fail_slot_invalid", 32'(oFoodValid), 2);
        check("fail_idle", 32'(oBusy), 0);
        iQueryHit = 1'b0;
        iEaten = 2'b01;
        tick(1);
        iEaten = 2'b00;
        tick(1);
        check("fail_eat_ignored", 32'(oBusy), 0);
        check("fail_still_sticky", 32'(oSpawnFail), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_food_manager.md
# snake_food_manager

Parametrised food subsystem for the Snake game. Holds up to NUM_FOOD food items on a cell grid inside the playfield, respawns each eaten item at an LFSR-random free cell, and drives the food icon for the pixel currently being scanned. It checks candidate cells against the snake body through a query handshake to the snake body block. Its icon output feeds the pixel mux alongside the world/border pixels.

## Interface
- NUM_FOOD, 2: food slots, 1..4
- GRID_W, 64: playfield width in cells
- GRID_H, 64: playfield height in cells
- CELL_BITS, 2: cell edge = 2^CELL_BITS pixels
- ORIGIN_X, 192: pixel column of cell (0,0)
- ORIGIN_Y, 112: pixel row of cell (0,0)
- SEED, 16'hACE1: LFSR reset value, must be nonzero
- MAX_TRIES, 8: candidate draws per spawn before giving up

Ports:
- Clock  in  1  system clock, all state on rising edge
- Reset  in  1  asynchronous, active-low
- iPixelRow  in  11  scan row
- iPixelCol  in  11  scan column
- iEaten  in  NUM_FOOD  one-cycle pulse per slot eaten
- iGameOver  in  1  freeze spawning, hide icons
- oQueryValid  out  1  body-occupancy query request
- oQueryX / oQueryY  out  8 / 8  candidate cell, zero-extended
- iQueryReady  in  1  body block accepts query this cycle
- iQueryHit  in  1  candidate occupied; valid when oQueryValid && iQueryReady
- oFoodValid  out  NUM_FOOD  slot holds live food
- oFoodLocationX / oFoodLocationY  out  11*NUM_FOOD each  top-left pixel of slot i at bits [11i+10:11i]
- oFoodIcon  out  2  2'b11 on food pixel, else 2'b00
- oSpawnFail  out  1  sticky: a spawn exhausted MAX_TRIES
- oBusy  out  1  FSM not IDLE

## Operation
- LFSR: 16-bit Fibonacci, shifts every cycle, new bit0 = b15^b13^b12^b10. Never held.
- Pending mask: set by reset (all ones) and by iEaten[i] when oFoodValid[i]=1 (pulse on invalid slot ignored). Eaten clears oFoodValid[i] next cycle.
- FSM IDLE -> DRAW when pending nonzero and iGameOver=0; lowest pending index selected, try counter = 0.
- DRAW: cx = lfsr[7:0] & (2^clog2(GRID_W)-1), cy = lfsr[15:8] & (2^clog2(GRID_H)-1). Reject (retry) if cx>=GRID_W, cy>=GRID_H, or (cx,cy) equals any other valid slot; else -> QUERY.
- QUERY: oQueryValid=1 with cx/cy held until iQueryReady. Accepted with iQueryHit=0 -> COMMIT; hit=1 -> retry.
- Retry: try counter+1; at MAX_TRIES set oSpawnFail, clear pending bit, slot stays invalid, -> IDLE; else -> DRAW.
- COMMIT: oFoodLocationX[i] = ORIGIN_X + (cx<<CELL_BITS), Y likewise (11-bit, no overflow for legal parameters); oFoodValid[i]=1, pending bit cleared, -> IDLE.
- iGameOver=1 in any state: abort to IDLE next cycle, oQueryValid deasserts, pending bits retained; spawning resumes when iGameOver falls.
- Icon: oFoodIcon = 2'b11 when iGameOver=0 and some valid slot has Col in [X, X+2^CELL_BITS) and Row in [Y, Y+2^CELL_BITS).

## Timing
- Reset values: oFoodValid=0, locations 0, oFoodIcon=0, oQueryValid=0, oSpawnFail=0, oBusy=0, LFSR=SEED, pending all ones, FSM IDLE.
- First DRAW in the first cycle after Reset deasserts.
- oFoodIcon registered: reflects pixel inputs from the previous cycle (1-cycle latency).
- Best-case spawn: IDLE, DRAW, QUERY (ready same cycle), COMMIT = valid asserted 4 cycles after the eaten pulse edge.
- iEaten on slot i while that slot is being spawned: ignored (slot invalid). Pulses on different slots in one cycle: all recorded, serviced lowest index first.
- oQueryX/Y stable and oQueryValid held high until accepted; no retraction except on iGameOver or Reset.
- Reset mid-spawn: immediate return to reset values; partial candidate discarded.

## Test plan
- Reset release, NUM_FOOD=2, iQueryReady=1, iQueryHit=0 -> slot 0 valid within 4 cycles, slot 1 within 8; both locations within [192,448)x[112,368), multiples of 4 from origin, distinct.
- iEaten=2'b01 pulse -> oFoodValid[0] low next cycle, high again ≤4 cycles later at new legal location; slot 1 unchanged.
- iQueryReady held low 10 cycles -> oQueryValid/X/Y stable all 10 cycles; commit 1 cycle after ready rises.
- iQueryHit forced 1 -> exactly MAX_TRIES=8 accepted queries (fewer draws if rejects), then oSpawnFail=1, slot invalid, oBusy=0.
- Food at (200,120): pixel (201,121) -> oFoodIcon=2'b11 one cycle later; (204,121) -> 2'b00; iGameOver=1 -> 2'b00.
- iGameOver asserted during QUERY -> oQueryValid low next cycle, FSM IDLE; deassert -> spawn of same slot completes.
